// File: rtl/tx_gearbox.sv
// rtl/tx_gearbox.sv - 66b-to-32b transmit gearbox, 64b/66b half-blocks in, 32-bit transceiver words out
// One pause cycle every 33 drains the 32-bit residue that builds up from the 2-bit headers.
module tx_gearbox #(
  parameter int DATA_WIDTH = 32,
  parameter int HDR_WIDTH  = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic [HDR_WIDTH-1:0]  i_tx_sync_hdr,
  input  logic                  i_tx_data_valid,
  output logic                  o_tx_data_ready,
  output logic [DATA_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_data_valid
);

  localparam int NEW_W = DATA_WIDTH + HDR_WIDTH;
  localparam int CAT_W = 2 * DATA_WIDTH;

  logic [5:0]            seq_cntr;
  logic [5:0]            seq_next;
  logic [5:0]            res_len;
  logic [DATA_WIDTH-1:0] residue;
  logic [NEW_W-1:0]      new_bits;
  logic [CAT_W-1:0]      cat;
  logic                  accept;
  logic                  pause;
  logic                  even;

  // Residue length is implied by the count: 2 bits per header already taken.
  always_comb begin
    pause    = (seq_cntr == 6'd32);
    accept   = o_tx_data_ready && i_tx_data_valid && !pause;
    even     = !seq_cntr[0];
    res_len  = seq_cntr + {5'b0, seq_cntr[0]};
    new_bits = even ? {i_tx_data, i_tx_sync_hdr} : {{HDR_WIDTH{1'b0}}, i_tx_data};
    cat      = ({{(CAT_W-NEW_W){1'b0}}, new_bits} << res_len)
             | {{(CAT_W-DATA_WIDTH){1'b0}}, residue};
    seq_next = seq_cntr;
    if (pause)
      seq_next = 6'd0;
    else if (accept)
      seq_next = seq_cntr + 6'd1;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      seq_cntr        <= 6'd0;
      residue         <= '0;
      o_tx_data       <= '0;
      o_tx_data_valid <= 1'b0;
      o_tx_data_ready <= 1'b1;
    end else begin
      seq_cntr        <= seq_next;
      o_tx_data_ready <= (seq_next != 6'd32);
      o_tx_data_valid <= pause || accept;
      if (pause) begin
        o_tx_data <= residue;
        residue   <= '0;
      end else if (accept) begin
        o_tx_data <= cat[DATA_WIDTH-1:0];
        residue   <= cat[CAT_W-1:DATA_WIDTH];
      end
    end
  end

endmodule

// File: tb/tb_tx_gearbox.sv
// tb/tb_tx_gearbox.sv - scoreboard bench for tx_gearbox against a bit-stream reference serialiser
module tb_tx_gearbox;

  logic        clk;
  logic        i_reset;
  logic [31:0] i_tx_data;
  logic [1:0]  i_tx_sync_hdr;
  logic        i_tx_data_valid;
  logic        o_tx_data_ready;
  logic [31:0] o_tx_data;
  logic        o_tx_data_valid;

  tx_gearbox #(.DATA_WIDTH(32), .HDR_WIDTH(2)) dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_tx_data       (i_tx_data),
    .i_tx_sync_hdr   (i_tx_sync_hdr),
    .i_tx_data_valid (i_tx_data_valid),
    .o_tx_data_ready (o_tx_data_ready),
    .o_tx_data       (o_tx_data),
    .o_tx_data_valid (o_tx_data_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          gaps = 0;
  int          stalls = 0;
  int          words_seen = 0;
  bit          bit_q[$];
  logic [31:0] exp_words[$];
  logic [31:0] obs_words[$];
  int          ready_lows[$];
  logic [31:0] exp_w;
  logic [63:0] blk_d[48];
  logic [1:0]  blk_h[48];

  // Scoreboard: every valid output word is popped against the reference stream.
  always @(negedge clk) begin
    if (o_tx_data_valid) begin
      checks++;
      if (exp_words.size() == 0) begin
        errors++;
        $display("FAIL sb_extra word %0d got %h required none", words_seen, o_tx_data);
      end else begin
        exp_w = exp_words.pop_front();
        if (o_tx_data !== exp_w) begin
          errors++;
          $display("FAIL sb_word %0d got %h required %h", words_seen, o_tx_data, exp_w);
        end
      end
      obs_words.push_back(o_tx_data);
      words_seen++;
    end
  end

  task automatic push_bits(input logic [33:0] v, input int n);
    logic [31:0] w;
    for (int i = 0; i < n; i++) bit_q.push_back(v[i]);
    while (bit_q.size() >= 32) begin
      for (int j = 0; j < 32; j++) w[j] = bit_q.pop_front();
      exp_words.push_back(w);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    cyc++;
    if (!o_tx_data_ready) ready_lows.push_back(cyc);
    if (!o_tx_data_valid) gaps++;
  endtask

  task automatic send_half(input logic [31:0] d, input logic [1:0] h, input bit even,
                           input int stall_pct, input bit garbage);
    int guard = 0;
    tick();
    while (!o_tx_data_ready || (int'($urandom_range(99)) < stall_pct)) begin
      if (o_tx_data_ready) stalls++;
      i_tx_data_valid = garbage && !o_tx_data_ready;
      i_tx_data       = 32'hDEAD_BEEF;
      i_tx_sync_hdr   = 2'b11;
      tick();
      guard++;
      if (guard > 64) begin
        $display("FAIL send_timeout ready=%0b after %0d cycles, required 1", o_tx_data_ready, guard);
        $fatal(1, "ready stuck low");
      end
    end
    i_tx_data_valid = 1'b1;
    i_tx_data       = d;
    i_tx_sync_hdr   = h;
    if (even) push_bits({d, h}, 34);
    else      push_bits({2'b00, d}, 32);
  endtask

  task automatic send_block(input logic [1:0] h, input logic [63:0] d, input int pct, input bit garbage);
    send_half(d[31:0], h, 1'b1, pct, garbage);
    send_half(d[63:32], h, 1'b0, pct, garbage);
  endtask

  task automatic tail(input int target);
    int guard = 0;
    tick();
    i_tx_data_valid = 1'b0;
    while (words_seen < target && guard < 100) begin
      tick();
      guard++;
    end
    checks++;
    if (words_seen != target) begin
      errors++;
      $display("FAIL word_count got %0d required %0d", words_seen, target);
    end
  endtask

  task automatic test_reset();
    tick();
    i_reset         = 1'b1;
    i_tx_data_valid = 1'b0;
    tick();
    tick();
    bit_q.delete();
    exp_words.delete();
    checks += 3;
    if (o_tx_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got %h required 00000000", o_tx_data);
    end
    if (o_tx_data_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got %b required 0", o_tx_data_valid);
    end
    if (o_tx_data_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b required 1", o_tx_data_ready);
    end
    i_reset    = 1'b0;
    cyc        = -1;
    gaps       = 0;
    stalls     = 0;
    words_seen = 0;
    obs_words.delete();
    ready_lows.delete();
  endtask

  task automatic test_known_words();
    logic [31:0] want[3];
    want[0] = 32'hFFFF_FFFD;
    want[1] = 32'h0000_0003;
    want[2] = 32'h0000_0008;
    test_reset();
    send_block(2'b01, {32'h0, 32'hFFFF_FFFF}, 0, 1'b0);
    send_block(2'b10, 64'h0, 0, 1'b0);
    tail(4);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs_words.size() <= k || obs_words[k] !== want[k]) begin
        errors++;
        $display("FAIL known_word %0d got %h required %h", k,
                 (obs_words.size() > k) ? obs_words[k] : 32'hx, want[k]);
      end
    end
  endtask

  task automatic check_ready_lows(input string name, input int n, input int a, input int b, input int c);
    int want[3];
    want[0] = a; want[1] = b; want[2] = c;
    checks++;
    if (ready_lows.size() != n) begin
      errors++;
      $display("FAIL %s_ready_low_count got %0d required %0d", name, ready_lows.size(), n);
    end else begin
      for (int i = 0; i < n; i++) begin
        checks++;
        if (ready_lows[i] != want[i]) begin
          errors++;
          $display("FAIL %s_ready_low_cycle got %0d required %0d", name, ready_lows[i], want[i]);
        end
      end
    end
  endtask

  task automatic test_continuous();
    test_reset();
    for (int b = 0; b < 48; b++) send_block(blk_h[b], blk_d[b], 0, 1'b0);
    tail(99);
    check_ready_lows("cont", 3, 32, 65, 98);
    checks += 2;
    if (gaps != 1) begin
      errors++;
      $display("FAIL cont_valid_gaps got %0d required 1", gaps);
    end
    if (exp_words.size() != 0 || bit_q.size() != 0) begin
      errors++;
      $display("FAIL cont_leftover got %0d words %0d bits required 0 0", exp_words.size(), bit_q.size());
    end
  endtask

  task automatic test_stalls();
    test_reset();
    for (int b = 0; b < 48; b++) send_block(blk_h[b], blk_d[b], 30, 1'b0);
    tail(99);
    checks += 2;
    if (gaps != stalls + 1) begin
      errors++;
      $display("FAIL stall_gaps got %0d required %0d", gaps, stalls + 1);
    end
    if (exp_words.size() != 0) begin
      errors++;
      $display("FAIL stall_leftover got %0d required 0", exp_words.size());
    end
  endtask

  function automatic logic [31:0] hdr11_word(input int k);
    logic [31:0] w;
    for (int j = 0; j < 32; j++) w[j] = (((32 * k + j) % 66) < 2);
    return w;
  endfunction

  task automatic test_pause_content();
    int idx[2];
    idx[0] = 16; idx[1] = 32;
    test_reset();
    for (int b = 0; b < 16; b++) send_block(2'b11, 64'h0, 0, 1'b0);
    tail(33);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (obs_words.size() <= idx[i] || obs_words[idx[i]] !== hdr11_word(idx[i])) begin
        errors++;
        $display("FAIL pause_word %0d got %h required %h", idx[i],
                 (obs_words.size() > idx[i]) ? obs_words[idx[i]] : 32'hx, hdr11_word(idx[i]));
      end
    end
    check_ready_lows("pause", 1, 32, 0, 0);
  endtask

  task automatic test_mid_reset();
    logic [31:0] lo;
    test_reset();
    for (int b = 0; b < 8; b++) send_block(blk_h[b], blk_d[b], 0, 1'b0);
    send_half(blk_d[8][31:0], blk_h[8], 1'b1, 0, 1'b0);
    test_reset();
    lo = blk_d[9][31:0];
    send_half(lo, 2'b10, 1'b1, 0, 1'b0);
    tick();
    i_tx_data_valid = 1'b0;
    checks++;
    if (o_tx_data_valid !== 1'b1 || o_tx_data !== {lo[29:0], 2'b10}) begin
      errors++;
      $display("FAIL post_reset_word got v=%b %h required v=1 %h", o_tx_data_valid, o_tx_data, {lo[29:0], 2'b10});
    end
    send_half(blk_d[9][63:32], 2'b10, 1'b0, 0, 1'b0);
    tail(2);
  endtask

  task automatic test_garbage();
    bit seen = 1'b0;
    test_reset();
    for (int b = 0; b < 17; b++) send_block(2'b01, 64'h0, 0, 1'b1);
    tail(35);
    foreach (obs_words[i]) if (obs_words[i] === 32'hDEAD_BEEF) seen = 1'b1;
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL garbage_leak got DEADBEEF in output required absent");
    end
    check_ready_lows("garbage", 1, 32, 0, 0);
  endtask

  initial begin
    i_reset         = 1'b1;
    i_tx_data       = '0;
    i_tx_sync_hdr   = '0;
    i_tx_data_valid = 1'b0;
    for (int b = 0; b < 48; b++) begin
      blk_d[b] = {$urandom, $urandom};
      blk_h[b] = ($urandom_range(1) == 0) ? 2'b01 : 2'b10;
    end
    test_reset();
    test_known_words();
    test_continuous();
    test_stalls();
    test_pause_content();
    test_mid_reset();
    test_garbage();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
